// File: rtl/volume_pkg.sv
// Shared definitions for the microphone volume meter and the display logic
// that consumes volume_level.
package volume_pkg;

  // Width and saturation value of the volume level seen by the display block.
  localparam int LEVEL_W   = 4;
  localparam int MAX_LEVEL = 9;

  // Offset-binary code produced by the microphone ADC for silence.
  localparam int MIDSCALE  = 2048;

  // Quantiser sequencing: load amplitude, count steps, publish result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUANT = 2'd1,
    DONE  = 2'd2
  } quant_state_e;

endpackage : volume_pkg

// File: rtl/mic_volume_meter_if.sv
// Sample-in / level-out signal bundle of the volume meter.
// master = the meter itself, slave = the sample source and level consumer.
interface mic_volume_meter_if #(
  parameter int SAMPLE_W = 12
) ();
  import volume_pkg::*;

  logic                sample_valid;
  logic [SAMPLE_W-1:0] mic_in;
  logic [LEVEL_W-1:0]  volume_level;
  logic                level_valid;
  logic                busy;

  modport master (
    input  sample_valid,
    input  mic_in,
    output volume_level,
    output level_valid,
    output busy
  );

  modport slave (
    output sample_valid,
    output mic_in,
    input  volume_level,
    input  level_valid,
    input  busy
  );

endinterface : mic_volume_meter_if

// File: rtl/peak_window.sv
// Peak tracker over a fixed number of sample strobes. Reports the peak of
// each completed window and flags the strobe that closes the window.
module peak_window #(
  parameter int SAMPLE_W       = 12,
  parameter int WINDOW_SAMPLES = 4000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] mic_in,
  output logic                window_done,
  output logic [SAMPLE_W-1:0] snap
);

  localparam int CNT_W = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW_SAMPLES - 1);

  logic [SAMPLE_W-1:0] peak_q, peak_d;
  logic [SAMPLE_W-1:0] snap_q, snap_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [SAMPLE_W-1:0] max_val;
  logic                last_sample;

  // Running maximum including the sample being presented this cycle.
  always_comb begin
    max_val     = (mic_in > peak_q) ? mic_in : peak_q;
    last_sample = sample_valid && (count_q == LAST_CNT);
  end

  // window_done is asserted in the strobe cycle itself so the quantiser can
  // start on the next edge; snap forwards the closing peak in that cycle and
  // the registered copy afterwards.
  always_comb begin
    window_done = last_sample;
    snap        = last_sample ? max_val : snap_q;
  end

  // Next-state for peak, count and snapshot; the closing sample is folded
  // into the snapshot and the new window starts empty.
  always_comb begin
    peak_d  = peak_q;
    count_d = count_q;
    snap_d  = snap_q;
    if (sample_valid) begin
      if (last_sample) begin
        snap_d  = max_val;
        peak_d  = '0;
        count_d = '0;
      end else begin
        peak_d  = max_val;
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Window state registers; reset discards any partial window.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q  <= '0;
      count_q <= '0;
      snap_q  <= '0;
    end else begin
      peak_q  <= peak_d;
      count_q <= count_d;
      snap_q  <= snap_d;
    end
  end

endmodule : peak_window

// File: rtl/mic_volume_meter.sv
// Microphone volume meter: per-window peak amplitude quantised into a
// 0..MAX_LEVEL level by repeated subtraction of STEP, one step per cycle.
module mic_volume_meter
  import volume_pkg::*;
#(
  parameter int SAMPLE_W       = 12,
  parameter int STEP           = 200,
  parameter int WINDOW_SAMPLES = 4000
) (
  input  logic               clk,
  input  logic               rst,
  mic_volume_meter_if.master bus
);

  localparam logic [SAMPLE_W-1:0] MID_C  = SAMPLE_W'(MIDSCALE);
  localparam logic [SAMPLE_W-1:0] STEP_C = SAMPLE_W'(STEP);
  localparam logic [LEVEL_W-1:0]  MAX_C  = LEVEL_W'(MAX_LEVEL);

  logic                window_done;
  logic [SAMPLE_W-1:0] snap;
  logic [SAMPLE_W-1:0] amp;

  quant_state_e        state_q, state_d;
  logic [SAMPLE_W-1:0] rem_q, rem_d;
  logic [LEVEL_W-1:0]  lvl_q, lvl_d;
  logic [LEVEL_W-1:0]  volume_level_q, volume_level_d;
  logic                level_valid_q, level_valid_d;

  peak_window #(
    .SAMPLE_W       (SAMPLE_W),
    .WINDOW_SAMPLES (WINDOW_SAMPLES)
  ) u_peak_window (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (bus.sample_valid),
    .mic_in       (bus.mic_in),
    .window_done  (window_done),
    .snap         (snap)
  );

  // Amplitude above silence; codes at or below midscale clamp to zero.
  always_comb begin
    amp = (snap > MID_C) ? (snap - MID_C) : '0;
  end

  // Quantiser next-state. A new window always restarts the count, which
  // drops any result still in flight. The output registers are loaded on
  // the QUANT->DONE transition so the new level is visible exactly during
  // the DONE cycle, together with the level_valid pulse.
  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    lvl_d          = lvl_q;
    volume_level_d = volume_level_q;
    level_valid_d  = 1'b0;
    if (window_done) begin
      state_d = QUANT;
      rem_d   = amp;
      lvl_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        QUANT: begin
          if ((rem_q >= STEP_C) && (lvl_q < MAX_C)) begin
            rem_d = rem_q - STEP_C;
            lvl_d = lvl_q + LEVEL_W'(1);
          end else begin
            state_d        = DONE;
            volume_level_d = lvl_q;
            level_valid_d  = 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Quantiser and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rem_q          <= '0;
      lvl_q          <= '0;
      volume_level_q <= '0;
      level_valid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      rem_q          <= rem_d;
      lvl_q          <= lvl_d;
      volume_level_q <= volume_level_d;
      level_valid_q  <= level_valid_d;
    end
  end

  // Drive the bundle from registered state only.
  always_comb begin
    bus.volume_level = volume_level_q;
    bus.level_valid  = level_valid_q;
    bus.busy         = (state_q != IDLE);
  end

endmodule : mic_volume_meter
